instruction_fetch_unit: RTL and testbench

//  Fetch stage upstream of the instruction memory (MemoriaInstrucciones).

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit_if_id_register.sv | 54 +++++
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   fetch_state_e : fetch FSM encoding (idle after reset, fetching, faulted)
//   PC_STEP       : byte distance between sequential instructions
//   NOP_INSTR     : MIPS sll $0,$0,0, shown on the IF/ID output when empty
//   is_aligned()  : true when a byte address is 32-bit word aligned
package instruction_fetch_unit_pkg;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit and its environment.
// The bundle carries three groups of signals: decode control, the instruction memory port, and the IF/ID payload.
//   master : the fetch unit
//   slave  : memory + decode side
// Signals:
//   stall, redirect, redirect_target      decode -> fetch
//   address, read_en, ce / data           fetch <-> instruction memory
//   if_pc, if_pc_plus4, if_instr, if_valid fetch -> decode
//   fetch_fault                           sticky fault indication
interface instruction_fetch_unit_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] address;
  logic        read_en;
  logic        ce;
  logic [31:0] data;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fetch_fault;

  modport master (
    input  stall, redirect, redirect_target, data,
    output address, read_en, ce,
    output if_pc, if_pc_plus4, if_instr, if_valid, fetch_fault
  );

  modport slave (
    output stall, redirect, redirect_target, data,
    input  address, read_en, ce,
    input  if_pc, if_pc_plus4, if_instr, if_valid, fetch_fault
  );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// The IF/ID pipeline register holds the fetched instruction and its PC until decode takes them.
//   clk, reset     : clock, async active-high reset
//   load_i         : capture pc_i / instr_i as a valid instruction
//   flush_i        : drop the held instruction (wins over load_i)
//   pc_i, instr_i  : PC being fetched and the memory word at that PC
//   if_*_o         : registered IF/ID contents
// With neither load_i nor flush_i asserted, every field holds (stall).
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o
);

  logic [31:0] if_pc_q;
  logic [31:0] if_pc_plus4_q;
  logic [31:0] if_instr_q;
  logic        if_valid_q;

  // A flush clears only the instruction and the valid flag.
  // The stale PC fields are never consumed while if_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      if_instr_q    <= NOP_WORD;
      if_valid_q    <= 1'b0;
    end else if (flush_i) begin
      if_instr_q    <= NOP_WORD;
      if_valid_q    <= 1'b0;
    end else if (load_i) begin
      if_pc_q       <= pc_i;
      if_pc_plus4_q <= pc_i + PC_STEP;
      if_instr_q    <= instr_i;
      if_valid_q    <= 1'b1;
    end
  end

  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc_plus4_q;
  assign if_instr_o    = if_instr_q;
  assign if_valid_o    = if_valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// This is the instruction fetch stage. It owns the PC, drives the instruction memory port,
// and fills the IF/ID register for decode.
//   clk, reset : clock, async active-high reset
//   bus        : master side of instruction_fetch_unit_if
//                (stall/redirect in, memory port, IF/ID payload, fetch_fault out)
// At each fetch cycle, a redirect wins over a stall, and a stall wins over a sequential fetch.
// A misaligned redirect, or a PC outside memory, parks the unit in S_FAULT.
// Only a later aligned, in-range redirect leaves S_FAULT.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD  = NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         fault_q;

  logic         in_fetch;
  logic         pc_in_range;
  logic         target_ok;
  logic         load;
  logic         flush;

  assign in_fetch    = (state_q == S_FETCH);
  assign pc_in_range = (pc_q < PC_LIMIT);
  assign target_ok   = is_aligned(bus.redirect_target) && (bus.redirect_target < PC_LIMIT);

  // The IF/ID register takes a new word only on an unstalled, in-range fetch cycle.
  // It is flushed when a redirect arrives, or when the current PC falls outside memory.
  assign load  = in_fetch && !bus.redirect && !bus.stall && pc_in_range;
  assign flush = in_fetch && (bus.redirect || (!bus.stall && !pc_in_range));

  // Fetch FSM: state, PC and sticky fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_target;
            if (!is_aligned(bus.redirect_target)) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end else if (!bus.stall) begin
            if (pc_in_range) begin
              pc_q <= pc_q + PC_STEP;
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (bus.redirect && target_ok) begin
            pc_q    <= bus.redirect_target;
            state_q <= S_FETCH;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The memory port is combinational from state, so the address-to-data path closes in one cycle.
  assign bus.address     = pc_q;
  assign bus.ce          = in_fetch;
  assign bus.read_en     = in_fetch && !bus.stall;
  assign bus.fetch_fault = fault_q;

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .flush_i       (flush),
    .pc_i          (pc_q),
    .instr_i       (bus.data),
    .if_pc_o       (bus.if_pc),
    .if_pc_plus4_o (bus.if_pc_plus4),
    .if_instr_o    (bus.if_instr),
    .if_valid_o    (bus.if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit.
// DUT a (1024 words) covers reset, stall, redirect, fault, and asynchronous reset.
// DUT b (16 words) covers running off the end of memory.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] LIM_A = 32'd4096;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_FAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic reset;
  logic rst_b;

  instruction_fetch_unit_if bus_a ();
  instruction_fetch_unit_if bus_b ();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (1024),
    .NOP_WORD  (32'h0000_0000)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (16),
    .NOP_WORD  (32'h0000_0000)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state for dut_a
  int          m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_fault;
  exp_t        sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a distinct non-NOP word per address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  always_comb bus_a.data = memfn(bus_a.address);
  always_comb bus_b.data = memfn(bus_b.address);

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    sb.delete();
  endtask

  // One clock of dut_a: drive, check memory port, advance model, check IF/ID via scoreboard
  task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt);
    logic pushed;
    logic exp_ce;
    logic exp_re;
    exp_t e;
    pushed = 1'b0;
    bus_a.stall           = st;
    bus_a.redirect        = rd;
    bus_a.redirect_target = tgt;
    #1;
    exp_ce = (m_state == M_FETCH);
    exp_re = exp_ce && !st;
    n_tests++;
    if (bus_a.address !== m_pc || bus_a.ce !== exp_ce || bus_a.read_en !== exp_re) begin
      n_fail++;
      $display("FAIL mem_port: address=%h ce=%b read_en=%b, expected address=%h ce=%b read_en=%b",
               bus_a.address, bus_a.ce, bus_a.read_en, m_pc, exp_ce, exp_re);
    end
    case (m_state)
      M_IDLE: m_state = M_FETCH;
      M_FETCH: begin
        if (rd) begin
          m_pc    = tgt;
          m_valid = 1'b0;
          if (tgt[1:0] != 2'b00) begin
            m_state = M_FAULT;
            m_fault = 1'b1;
          end
        end else if (!st) begin
          if (m_pc >= LIM_A) begin
            m_valid = 1'b0;
            m_state = M_FAULT;
            m_fault = 1'b1;
          end else begin
            sb.push_back('{pc: m_pc, instr: memfn(m_pc)});
            pushed  = 1'b1;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
          end
        end
      end
      default: begin
        if (rd && tgt[1:0] == 2'b00 && tgt < LIM_A) begin
          m_pc    = tgt;
          m_state = M_FETCH;
          m_fault = 1'b0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    n_tests++;
    if (bus_a.if_valid !== m_valid || bus_a.fetch_fault !== m_fault) begin
      n_fail++;
      $display("FAIL status: if_valid=%b fetch_fault=%b, expected if_valid=%b fetch_fault=%b",
               bus_a.if_valid, bus_a.fetch_fault, m_valid, m_fault);
    end
    if (!m_valid) begin
      n_tests++;
      if (bus_a.if_instr !== NOP) begin
        n_fail++;
        $display("FAIL empty_nop: if_instr=%h expected %h", bus_a.if_instr, NOP);
      end
    end
    if (pushed) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: queue empty on capture");
      end else begin
        e = sb.pop_front();
        if (bus_a.if_pc !== e.pc || bus_a.if_pc_plus4 !== e.pc + 32'd4 || bus_a.if_instr !== e.instr) begin
          n_fail++;
          $display("FAIL capture: if_pc=%h if_pc_plus4=%h if_instr=%h, expected %h %h %h",
                   bus_a.if_pc, bus_a.if_pc_plus4, bus_a.if_instr, e.pc, e.pc + 32'd4, e.instr);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_target = 32'h0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus_a.address !== 32'h0 || bus_a.ce !== 1'b0 || bus_a.read_en !== 1'b0 ||
        bus_a.if_pc !== 32'h0 || bus_a.if_pc_plus4 !== 32'h0 || bus_a.if_instr !== NOP ||
        bus_a.if_valid !== 1'b0 || bus_a.fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h ce=%b re=%b pc=%h pc4=%h instr=%h v=%b f=%b, expected all zero",
               bus_a.address, bus_a.ce, bus_a.read_en, bus_a.if_pc, bus_a.if_pc_plus4,
               bus_a.if_instr, bus_a.if_valid, bus_a.fetch_fault);
    end
    reset = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 32'h0);   // idle cycle
    cyc(1'b0, 1'b0, 32'h0);   // fetch 0
    n_tests++;
    if (bus_a.if_instr !== memfn(32'h0) || bus_a.if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_fetch: if_instr=%h if_valid=%b, expected %h 1",
               bus_a.if_instr, bus_a.if_valid, memfn(32'h0));
    end
    cyc(1'b0, 1'b0, 32'h0);   // fetch 4
    cyc(1'b0, 1'b0, 32'h0);   // fetch 8
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      n_tests++;
      if (bus_a.address !== 32'hC || bus_a.if_pc !== 32'h8 ||
          bus_a.if_instr !== memfn(32'h8) || bus_a.if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: addr=%h if_pc=%h if_instr=%h v=%b, expected 0000000c 00000008 %h 1",
                 i, bus_a.address, bus_a.if_pc, bus_a.if_instr, bus_a.if_valid, memfn(32'h8));
      end
    end
    cyc(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (bus_a.if_pc !== 32'hC || bus_a.if_instr !== memfn(32'hC)) begin
      n_fail++;
      $display("FAIL stall_resume: if_pc=%h if_instr=%h, expected 0000000c %h",
               bus_a.if_pc, bus_a.if_instr, memfn(32'hC));
    end
  endtask

  task automatic test_redirect_stall();
    cyc(1'b1, 1'b1, 32'h214);
    n_tests++;
    if (bus_a.if_valid !== 1'b0 || bus_a.address !== 32'h214) begin
      n_fail++;
      $display("FAIL redirect_flush: if_valid=%b address=%h, expected 0 00000214",
               bus_a.if_valid, bus_a.address);
    end
    cyc(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (bus_a.if_pc !== 32'h214 || bus_a.if_pc_plus4 !== 32'h218 || bus_a.if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_target: if_pc=%h if_pc_plus4=%h v=%b, expected 00000214 00000218 1",
               bus_a.if_pc, bus_a.if_pc_plus4, bus_a.if_valid);
    end
  endtask

  task automatic test_misaligned();
    cyc(1'b0, 1'b1, 32'h58D);
    n_tests++;
    if (bus_a.fetch_fault !== 1'b1 || bus_a.ce !== 1'b0 || bus_a.read_en !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_fault: fault=%b ce=%b read_en=%b, expected 1 0 0",
               bus_a.fetch_fault, bus_a.ce, bus_a.read_en);
    end
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h2000);   // aligned but out of range: stays faulted
    n_tests++;
    if (bus_a.fetch_fault !== 1'b1 || bus_a.address !== 32'h58D) begin
      n_fail++;
      $display("FAIL fault_stays: fault=%b address=%h, expected 1 0000058d",
               bus_a.fetch_fault, bus_a.address);
    end
    cyc(1'b0, 1'b1, 32'h20);
    n_tests++;
    if (bus_a.fetch_fault !== 1'b0 || bus_a.ce !== 1'b1 || bus_a.address !== 32'h20) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b ce=%b address=%h, expected 0 1 00000020",
               bus_a.fetch_fault, bus_a.ce, bus_a.address);
    end
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_range();
    int          edges;
    logic [31:0] last_pc;
    edges   = 0;
    last_pc = 32'hFFFF_FFFF;
    rst_b   = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    while (bus_b.fetch_fault !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus_b.if_valid === 1'b1) last_pc = bus_b.if_pc;
    end
    n_tests++;
    if (bus_b.fetch_fault !== 1'b1 || edges != 18) begin
      n_fail++;
      $display("FAIL range_fault: fault=%b after %0d edges, expected 1 after 18", bus_b.fetch_fault, edges);
    end
    n_tests++;
    if (bus_b.if_valid !== 1'b0 || last_pc !== 32'h3C || bus_b.address !== 32'h40 ||
        bus_b.ce !== 1'b0 || bus_b.if_instr !== NOP) begin
      n_fail++;
      $display("FAIL range_state: v=%b last_pc=%h addr=%h ce=%b instr=%h, expected 0 0000003c 00000040 0 %h",
               bus_b.if_valid, last_pc, bus_b.address, bus_b.ce, bus_b.if_instr, NOP);
    end
  endtask

  task automatic test_reset_mid_stall();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    n_tests++;
    if (bus_a.address !== 32'h30 || bus_a.if_pc !== 32'h2C) begin
      n_fail++;
      $display("FAIL pre_reset: address=%h if_pc=%h, expected 00000030 0000002c", bus_a.address, bus_a.if_pc);
    end
    bus_a.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus_a.address !== 32'h0 || bus_a.ce !== 1'b0 || bus_a.read_en !== 1'b0 ||
        bus_a.if_pc !== 32'h0 || bus_a.if_instr !== NOP || bus_a.if_valid !== 1'b0 ||
        bus_a.fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h ce=%b re=%b if_pc=%h instr=%h v=%b f=%b, expected reset values",
               bus_a.address, bus_a.ce, bus_a.read_en, bus_a.if_pc, bus_a.if_instr,
               bus_a.if_valid, bus_a.fetch_fault);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (bus_a.if_pc !== 32'h0 || bus_a.if_instr !== memfn(32'h0) || bus_a.if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: if_pc=%h if_instr=%h v=%b, expected 00000000 %h 1",
               bus_a.if_pc, bus_a.if_instr, bus_a.if_valid, memfn(32'h0));
    end
    cyc(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    rst_b = 1'b1;
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_target = 32'h0;
    bus_b.stall = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_target = 32'h0;
    model_reset();
    test_reset();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_range();
    test_reset_mid_stall();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
